// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester and FIFO-side bundle for fifo_wr_arbiter
//
// Signals:
//   req        NUM_REQ             per-requester write request (level, held until ack)
//   req_data   NUM_REQ*DATA_WIDTH  requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack        NUM_REQ             one-cycle accept pulse per requester
//   fifo_count ADDR_WIDTH+1        occupancy reported by the shared FIFO
//   fifo_enQ   1                   registered enqueue strobe
//   fifo_data  DATA_WIDTH          registered enqueue word
//   stall      1                   requests pending but blocked by a full FIFO
// Modports: slave = arbiter side, master = requesters/FIFO/environment side.
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            ack;
    logic [ADDR_WIDTH:0]           fifo_count;
    logic                          fifo_enQ;
    logic [DATA_WIDTH-1:0]         fifo_data;
    logic                          stall;

    modport slave (
        input  req, req_data, fifo_count,
        output ack, fifo_enQ, fifo_data, stall
    );

    modport master (
        output req, req_data, fifo_count,
        input  ack, fifo_enQ, fifo_data, stall
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - N-way write arbiter feeding one shared FIFO
//
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    fifo_wr_arbiter_if.slave (req/req_data in, ack out, fifo_count in,
//          fifo_enQ/fifo_data/stall out)
// Configuration macro: FIFO_WR_ARBITER_PRIORITY_EN
//   undefined -> round-robin starting at rr_ptr
//   defined   -> fixed priority, lowest asserted index wins, rr_ptr held at 0
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REQ    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    fifo_wr_arbiter_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 2;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {RUN = 1'b0, FULL = 1'b1} state_t;

    state_t             state, state_next;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   win;
    logic               found;
    int                 search_idx;
    logic [CW-1:0]      occ_sum;
    logic               space_ok;
    logic               any_req;
    logic               grant;

    // The enqueue issued last cycle is not yet visible in fifo_count, so it
    // is added here; the wide sum keeps DEPTH + 1 from wrapping.
    assign occ_sum  = {1'b0, bus.fifo_count} + CW'(bus.fifo_enQ);
    assign space_ok = occ_sum < CW'(DEPTH);
    assign any_req  = |bus.req;

    // Winner search: first asserted request starting at the search origin.
    always_comb begin
        found      = 1'b0;
        win        = '0;
        search_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef FIFO_WR_ARBITER_PRIORITY_EN
            search_idx = k;
`else
            search_idx = (int'(rr_ptr) + k) % NUM_REQ;
`endif
            if (!found && bus.req[search_idx]) begin
                found = 1'b1;
                win   = PTR_W'(search_idx);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state: FULL only while someone is waiting on a full FIFO. Leaving
    // FULL happens on the same cycle the grant is issued, and a withdrawn
    // request also drops back to RUN.
    always_comb begin
        state_next = RUN;
        if (any_req && !space_ok) begin
            state_next = FULL;
        end
    end

    // Output decode. Grants are legal in both states; FULL only records that
    // the previous cycle was blocked.
    always_comb begin
        grant     = any_req && space_ok;
        bus.stall = (state == FULL);
    end

    // Registered enqueue/ack datapath and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ack       <= '0;
            bus.fifo_enQ  <= 1'b0;
            bus.fifo_data <= '0;
            rr_ptr        <= '0;
        end else begin
            bus.fifo_enQ <= grant;
            if (grant) begin
                bus.ack       <= NUM_REQ'(1) << win;
                bus.fifo_data <= bus.req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
`ifdef FIFO_WR_ARBITER_PRIORITY_EN
                rr_ptr        <= '0;
`else
                rr_ptr        <= (int'(win) == NUM_REQ - 1) ? '0 : win + PTR_W'(1);
`endif
            end else begin
                bus.ack       <= '0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   e;

    fifo_wr_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_REQ(4)) bus ();

    fifo_wr_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_REQ(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] ack_e, input logic enq_e,
                           input logic [7:0] data_e, input logic stall_e);
        chk({tag, "_ack"},   32'(bus.ack),       32'(ack_e));
        chk({tag, "_enq"},   32'(bus.fifo_enQ),  32'(enq_e));
        chk({tag, "_data"},  32'(bus.fifo_data), 32'(data_e));
        chk({tag, "_stall"}, 32'(bus.stall),     32'(stall_e));
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        bus.req        = 4'b0000;
        bus.req_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bus.fifo_count = 9'd0;

        // Reset state
        step();
        step();
        chk_out("reset", 4'b0000, 1'b0, 8'h00, 1'b0);

        // Single request, first edge after release
        rst_n   = 1'b1;
        bus.req = 4'b0001;
        step();
        chk_out("first", 4'b0001, 1'b1, 8'hA0, 1'b0);
        bus.req = 4'b0000;
        step();
        chk_out("idle_hold", 4'b0000, 1'b0, 8'hA0, 1'b0);

        // All four requesting; rr_ptr is 1 after the grant to requester 0
        bus.req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
`ifdef FIFO_WR_ARBITER_PRIORITY_EN
            e = 0;
`else
            e = (1 + k) % 4;
`endif
            chk("rr_ack",  32'(bus.ack),       32'(1) << e);
            chk("rr_data", 32'(bus.fifo_data), 32'h0A0 + 32'(e));
            chk("rr_enq",  32'(bus.fifo_enQ),  32'h1);
        end
        bus.req = 4'b0000;
        step();

        // DEPTH-1 occupancy: one grant, then blocked while the enQ is in flight
        bus.fifo_count = 9'd255;
        bus.req        = 4'b0001;
        step();
        chk_out("near_full_grant", 4'b0001, 1'b1, 8'hA0, 1'b0);
        step();
        chk_out("near_full_block", 4'b0000, 1'b0, 8'hA0, 1'b1);
        bus.fifo_count = 9'd256;
        step();
        chk_out("full_hold", 4'b0000, 1'b0, 8'hA0, 1'b1);
        bus.fifo_count = 9'd254;
        step();
        chk_out("space_back", 4'b0001, 1'b1, 8'hA0, 1'b0);
        bus.req        = 4'b0000;
        bus.fifo_count = 9'd0;
        step();

        // Completely full with two requesters, then drained
        bus.fifo_count = 9'd256;
        bus.req        = 4'b0110;
        step();
        chk_out("full_a", 4'b0000, 1'b0, 8'hA0, 1'b1);
        step();
        chk_out("full_b", 4'b0000, 1'b0, 8'hA0, 1'b1);
        bus.fifo_count = 9'd0;
        step();
        chk_out("drain_1", 4'b0010, 1'b1, 8'hA1, 1'b0);
        bus.req = 4'b0100;
        step();
        chk_out("drain_2", 4'b0100, 1'b1, 8'hA2, 1'b0);
        bus.req = 4'b0000;
        step();

        // Reset in the cycle after a grant
        bus.req = 4'b0010;
        step();
        chk_out("pre_reset", 4'b0010, 1'b1, 8'hA1, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk_out("mid_reset", 4'b0000, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        bus.req = 4'b1111;
        step();
        chk("rr_after_reset", 32'(bus.ack), 32'b0001);
        bus.req = 4'b1000;
        step();
        chk_out("post_reset", 4'b1000, 1'b1, 8'hA3, 1'b0);

        // Short pulse on requester 2 while pointed at it and no space
        bus.req = 4'b0010;
        step();
        chk("set_ptr_ack", 32'(bus.ack), 32'b0010);
        bus.req        = 4'b0100;
        bus.fifo_count = 9'd256;
        step();
        chk_out("pulse_blocked", 4'b0000, 1'b0, 8'hA1, 1'b1);
        bus.req = 4'b0000;
        step();
        chk_out("pulse_gone", 4'b0000, 1'b0, 8'hA1, 1'b0);
        bus.fifo_count = 9'd0;
        step();
        chk_out("pulse_never", 4'b0000, 1'b0, 8'hA1, 1'b0);

        // Single active requester gets every cycle
        bus.req = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out("stream", 4'b0001, 1'b1, 8'hA0, 1'b0);
        end
        bus.req = 4'b0000;
        step();
        chk_out("stream_end", 4'b0000, 1'b0, 8'hA0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
